// File: rtl/fp_mul_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_pkg
// Shared definitions for the iterative floating-point multiplier:
//   - state_e      : FSM state encoding (ST_ROUND only with FP_MUL_ROUND_EN)
//   - fp_bias      : exponent bias for a given exponent width
//   - fp_exp_max   : all-ones exponent code (inf/NaN) for a given width
//   - fp_qnan      : canonical quiet NaN pattern, right-aligned in 64 bits
//   - fp_exp_lsb / fp_sign_pos : bit positions of the packed fields
// -----------------------------------------------------------------------------
package fp_mul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_MULT   = 3'd2,
    ST_NORM   = 3'd3,
`ifdef FP_MUL_ROUND_EN
    ST_ROUND  = 3'd4,
`endif
    ST_DONE   = 3'd5
  } state_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Sign 0, exponent all ones, fraction MSB set, everything else clear.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[frac_w + i] = 1'b1;
    v[frac_w - 1] = 1'b1;
    return v;
  endfunction

  function automatic int fp_exp_lsb(input int frac_w);
    return frac_w;
  endfunction

  function automatic int fp_sign_pos(input int exp_w, input int frac_w);
    return exp_w + frac_w;
  endfunction

endpackage

// File: rtl/fp_mul_mantissa.sv
// -----------------------------------------------------------------------------
// fp_mul_mantissa
// Shift-add mantissa multiplier, one multiplier bit per step, LSB first.
// Ports:
//   clk          in   clock, rising edge
//   load         in   clear the upper half and load the multiplier
//   step         in   perform one add/shift iteration
//   multiplicand in   FRAC_W+1 bits (hidden one included)
//   multiplier   in   FRAC_W+1 bits (hidden one included)
//   product      out  2*(FRAC_W+1) bit accumulator, final after FRAC_W+1 steps
//   last         out  high during the step that completes the product
// -----------------------------------------------------------------------------
module fp_mul_mantissa
  import fp_mul_pkg::*;
#(
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic                  step,
  input  logic [FRAC_W:0]       multiplicand,
  input  logic [FRAC_W:0]       multiplier,
  output logic [2*FRAC_W+1:0]   product,
  output logic                  last
);

  localparam int M  = FRAC_W + 1;
  localparam int CW = $clog2(M + 1);

  logic [2*M-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M:0]     psum;

  // The lower half starts as the multiplier and is consumed from bit 0 while
  // the partial sum shifts in from the top, so no separate shift register.
  always_comb begin
    psum  = {1'b0, acc_q[2*M-1:M]} + (acc_q[0] ? {1'b0, multiplicand} : '0);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = {{M{1'b0}}, multiplier};
      cnt_d = '0;
    end else if (step) begin
      acc_d = {psum, acc_q[M-1:1]};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    cnt_q <= cnt_d;
  end

  assign last    = step && (cnt_q == CW'(M - 1));
  assign product = acc_q;

endmodule

// File: rtl/fp_multiplier_iter.sv
// -----------------------------------------------------------------------------
// fp_multiplier_iter
// Iterative floating-point multiplier: operands accepted on start/ready, the
// mantissa product is built one bit per cycle, then normalised, optionally
// rounded (FP_MUL_ROUND_EN), and presented with a one-cycle done pulse.
// Build option: define FP_MUL_ROUND_EN for round-to-nearest-even (adds the
// ROUND state, one cycle); otherwise the result is truncated.
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   request, accepted while ready=1
//   a, b       in   packed operands {sign, exp, frac}
//   ready      out  high in IDLE and DONE
//   done       out  one-cycle completion pulse
//   result     out  packed product, held until the next done
//   overflow, underflow, invalid  out  status of the current result
// -----------------------------------------------------------------------------
module fp_multiplier_iter
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    ready,
  output logic                    done,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    invalid
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int M  = FRAC_W + 1;
  localparam int XW = EXP_W + 2;
  localparam int EXP_LSB  = fp_exp_lsb(FRAC_W);
  localparam int SIGN_POS = fp_sign_pos(EXP_W, FRAC_W);

  localparam logic signed [XW-1:0] BIAS    = XW'(fp_bias(EXP_W));
  localparam logic signed [XW-1:0] EXP_MAX = XW'(fp_exp_max(EXP_W));
  localparam logic signed [XW-1:0] EONE    = XW'(1);
  localparam logic signed [XW-1:0] EZERO   = '0;
  localparam logic [W-1:0]         QNAN    = W'(fp_qnan(EXP_W, FRAC_W));

  // Returns {overflow, underflow, packed result}; no denormals are produced.
  function automatic logic [W+1:0] pack_res(input logic s,
                                            input logic signed [XW-1:0] e,
                                            input logic [FRAC_W-1:0] f);
    if (e >= EXP_MAX)
      return {2'b10, s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (e <= EZERO)
      return {2'b01, s, {(W-1){1'b0}}};
    else
      return {2'b00, s, e[EXP_W-1:0], f};
  endfunction

`ifdef FP_MUL_ROUND_EN
  // Round-to-nearest-even; returns {carry, fraction}. On carry the fraction
  // has wrapped to zero, which is exactly the renormalised 1.000... value.
  function automatic logic [FRAC_W:0] rnd_rne(input logic [FRAC_W-1:0] f,
                                              input logic g, input logic s);
    logic inc;
    inc = g & (s | f[0]);
    return {1'b0, f} + {{FRAC_W{1'b0}}, inc};
  endfunction
`endif

  state_e state_q, state_d;
  logic   unpk_ph_q;
  logic   accept;

  logic [W-1:0] a_q, b_q;
  logic         sign_q;
  logic signed [XW-1:0] exp_q;
  logic         spec_q, spec_inv_q;
  logic [W-1:0] spec_res_q;

  logic [W-1:0] result_q, result_d;
  logic         ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  // ---------------------------------------------------------------- unpack
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
  logic signed [XW-1:0] exp_sum;
  logic         spec_hit, spec_inv;
  logic [W-1:0] spec_res;

  assign ea  = a_q[EXP_LSB +: EXP_W];
  assign eb  = b_q[EXP_LSB +: EXP_W];
  assign fa  = a_q[FRAC_W-1:0];
  assign fb  = b_q[FRAC_W-1:0];
  assign sgn = a_q[SIGN_POS] ^ b_q[SIGN_POS];

  // Exponent zero covers both zero and denormals: both flush to zero.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  always_comb begin
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ---------------------------------------------------------------- mult
  logic           m_load, m_step, m_last;
  logic [2*M-1:0] prod;

  assign m_load = (state_q == ST_UNPACK) && unpk_ph_q && !spec_q;
  assign m_step = (state_q == ST_MULT);

  fp_mul_mantissa #(.FRAC_W(FRAC_W)) u_mant (
    .clk          (clk),
    .load         (m_load),
    .step         (m_step),
    .multiplicand ({1'b1, fa}),
    .multiplier   ({1'b1, fb}),
    .product      (prod),
    .last         (m_last)
  );

  // ---------------------------------------------------------------- norm
  logic [FRAC_W-1:0]    nf;
  logic                 ng, ns;
  logic signed [XW-1:0] ne;

  // Product of two [1,2) mantissas lies in [1,4): at most one right shift.
  always_comb begin
    if (prod[2*M-1]) begin
      nf = prod[2*M-2 -: FRAC_W];
      ng = prod[M-1];
      ns = |prod[M-2:0];
      ne = exp_q + EONE;
    end else begin
      nf = prod[2*M-3 -: FRAC_W];
      ng = prod[M-2];
      ns = |prod[M-3:0];
      ne = exp_q;
    end
  end

`ifdef FP_MUL_ROUND_EN
  logic [FRAC_W-1:0]    frac_n_q;
  logic signed [XW-1:0] exp_n_q;
  logic                 grd_q, stk_q;
  logic [FRAC_W:0]      rnd;

  assign rnd = rnd_rne(frac_n_q, grd_q, stk_q);
`else
  // Guard and sticky are discarded when truncating.
  logic norm_unused;
  assign norm_unused = ng ^ ns;
`endif

  // ---------------------------------------------------------------- fsm
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      unpk_ph_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // UNPACK spends one cycle registering the decode, one dispatching it.
      unpk_ph_q <= (state_q == ST_UNPACK) && !unpk_ph_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_UNPACK;
      ST_UNPACK: if (unpk_ph_q) state_d = spec_q ? ST_DONE : ST_MULT;
      ST_MULT:   if (m_last) state_d = ST_NORM;
`ifdef FP_MUL_ROUND_EN
      ST_NORM:   state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_DONE;
`else
      ST_NORM:   state_d = ST_DONE;
`endif
      ST_DONE:   state_d = start ? ST_UNPACK : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    done  = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
    if ((state_q == ST_UNPACK) && !unpk_ph_q) begin
      sign_q     <= sgn;
      exp_q      <= exp_sum;
      spec_q     <= spec_hit;
      spec_inv_q <= spec_inv;
      spec_res_q <= spec_res;
    end
`ifdef FP_MUL_ROUND_EN
    if (state_q == ST_NORM) begin
      frac_n_q <= nf;
      exp_n_q  <= ne;
      grd_q    <= ng;
      stk_q    <= ns;
    end
`endif
  end

  // ---------------------------------------------------------------- output
  always_comb begin
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inv_d    = inv_q;
    if (state_q == ST_UNPACK) begin
      result_d = spec_res_q;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      inv_d    = spec_inv_q;
    end else begin
`ifdef FP_MUL_ROUND_EN
      {ovf_d, unf_d, result_d} = pack_res(sign_q,
                                          rnd[FRAC_W] ? exp_n_q + EONE : exp_n_q,
                                          rnd[FRAC_W-1:0]);
`else
      {ovf_d, unf_d, result_d} = pack_res(sign_q, ne, nf);
`endif
      inv_d = 1'b0;
    end
  end

  // Result and flags change only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inv_q    <= inv_d;
    end
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule
